// File: rtl/mmio_unit_if.sv
// mmio_unit_if: MMIO access bus plus UART RX/TX handshakes and retire pulse for mmio_unit
interface mmio_unit_if;
    logic [2:0]  mmap_sel;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  wr_data;
    logic        inst_retired;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [31:0] rd_data;
    modport slave (
        input  mmap_sel, mem_en, mem_we, wr_data, inst_retired, uart_rx_data, uart_rx_valid, uart_tx_ready,
        output uart_rx_ready, uart_tx_data, uart_tx_valid, rd_data
    );
    modport master (
        output mmap_sel, mem_en, mem_we, wr_data, inst_retired, uart_rx_data, uart_rx_valid, uart_tx_ready,
        input  uart_rx_ready, uart_tx_data, uart_tx_valid, rd_data
    );
endinterface

// File: rtl/mmio_unit.sv
// mmio_unit: MMIO back end with UART RX FIFO, TX holding register and cycle/instruction counters.
// Defining MMIO_ERR_FLAGS_EN adds sticky tx_drop/rx_underflow flags in CTRL bits 2/3.
module mmio_unit #(
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input logic        clk,
    input logic        rst,
    mmio_unit_if.slave bus
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, BUSY} tx_state_t;
    tx_state_t        tx_state_q, tx_state_d;
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [7:0]       rx_mem_d [RX_DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;
    logic [31:0]      rd_q, rd_d, ctrl;
    logic [1:0]       flags;
    logic             load, store, rx_full, rx_empty, push, rx_ld, pop, tx_st, cnt_clr;
    always_comb begin
        load       = bus.mem_en && !bus.mem_we;
        store      = bus.mem_en && bus.mem_we;
        rx_full    = cnt_q == CW'(RX_DEPTH);
        rx_empty   = cnt_q == '0;
        push       = bus.uart_rx_valid && !rx_full;
        rx_ld      = load && bus.mmap_sel == 3'd1;
        pop        = rx_ld && !rx_empty;
        tx_st      = store && bus.mmap_sel == 3'd2;
        cnt_clr    = store && bus.mmap_sel == 3'd5;
        rx_mem_d   = rx_mem_q;
        if (push) rx_mem_d[wp_q] = bus.uart_rx_data;
        wp_d       = wp_q + PW'(push);
        rp_d       = rp_q + PW'(pop);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        tx_state_d = tx_state_q == IDLE ? (tx_st ? BUSY : IDLE) : (bus.uart_tx_ready ? IDLE : BUSY);
        tx_data_d  = tx_st && tx_state_q == IDLE ? bus.wr_data : tx_data_q;
        cyc_d      = cnt_clr ? '0 : cyc_q + CNT_W'(1);
        inst_d     = cnt_clr ? '0 : inst_q + CNT_W'(bus.inst_retired);
        ctrl       = {28'b0, flags, !rx_empty, tx_state_q == IDLE};
        rd_d       = !load                ? '0 :
                     bus.mmap_sel == 3'd0 ? ctrl :
                     bus.mmap_sel == 3'd1 ? (pop ? {24'b0, rx_mem_q[rp_q]} : '0) :
                     bus.mmap_sel == 3'd3 ? 32'(cyc_q) :
                     bus.mmap_sel == 3'd4 ? 32'(inst_q) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_mem_q   <= '{default: '0};
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            tx_state_q <= IDLE;
            tx_data_q  <= '0;
            cyc_q      <= '0;
            inst_q     <= '0;
            rd_q       <= '0;
        end else begin
            rx_mem_q   <= rx_mem_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            rd_q       <= rd_d;
        end
    end
`ifdef MMIO_ERR_FLAGS_EN
    logic [1:0] flags_q, flags_d;
    // {rx_underflow, tx_drop}: a CTRL load clears, but a same-cycle set event wins
    always_comb flags_d = {rx_ld && rx_empty, tx_st && tx_state_q == BUSY} |
                          (load && bus.mmap_sel == 3'd0 ? 2'b00 : flags_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= '0;
        else flags_q <= flags_d;
    end
    assign flags = flags_q;
`else
    assign flags = 2'b00;
`endif
    assign bus.uart_rx_ready = !rx_full;
    assign bus.uart_tx_valid = tx_state_q == BUSY;
    assign bus.uart_tx_data  = tx_data_q;
    assign bus.rd_data       = rd_q;
endmodule

// File: tb/tb_mmio_unit.sv
// tb_mmio_unit: directed stimulus with a queue-based reference model checked every cycle
module tb_mmio_unit;
    localparam int DEPTH = 4;
    localparam int CW = 4;
`ifdef MMIO_ERR_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    mmio_unit_if bus();
    mmio_unit #(.RX_DEPTH(DEPTH), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    logic [7:0]  m_q[$];
    bit          m_busy = 0;
    logic [7:0]  m_tx = 8'h00;
    int          m_cyc = 0;
    int          m_inst = 0;
    logic [31:0] m_rd = 32'h0;
    bit          m_drop = 0;
    bit          m_uf = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = {};
            m_busy = 0; m_tx = 8'h00; m_cyc = 0; m_inst = 0; m_rd = 32'h0; m_drop = 0; m_uf = 0;
        end else begin
            bit ld, st, ready, drop_ev, uf_ev;
            ld = bus.mem_en && !bus.mem_we;
            st = bus.mem_en && bus.mem_we;
            ready = m_q.size() < DEPTH;
            m_rd = 32'h0;
            drop_ev = 0;
            uf_ev = 0;
            if (ld) begin
                case (bus.mmap_sel)
                    3'd0: begin
                        m_rd = {28'b0, FL && m_uf, FL && m_drop, m_q.size() != 0, !m_busy};
                        m_drop = 0;
                        m_uf = 0;
                    end
                    3'd1: if (m_q.size() != 0) m_rd = 32'(m_q.pop_front()); else uf_ev = 1;
                    3'd3: m_rd = m_cyc;
                    3'd4: m_rd = m_inst;
                    default: ;
                endcase
            end
            if (bus.uart_rx_valid && ready) m_q.push_back(bus.uart_rx_data);
            if (m_busy) begin
                if (st && bus.mmap_sel == 3'd2) drop_ev = 1;
                if (bus.uart_tx_ready) m_busy = 0;
            end else if (st && bus.mmap_sel == 3'd2) begin
                m_busy = 1;
                m_tx = bus.wr_data;
            end
            m_drop = m_drop || drop_ev;
            m_uf = m_uf || uf_ev;
            if (st && bus.mmap_sel == 3'd5) begin
                m_cyc = 0;
                m_inst = 0;
            end else begin
                m_cyc = (m_cyc + 1) % (1 << CW);
                m_inst = (m_inst + int'(bus.inst_retired)) % (1 << CW);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("rd_data", bus.rd_data, m_rd);
            check("tx_valid", 32'(bus.uart_tx_valid), 32'(m_busy));
            check("tx_data", 32'(bus.uart_tx_data), 32'(m_tx));
            check("rx_ready", 32'(bus.uart_rx_ready), 32'(m_q.size() < DEPTH));
        end
    end

    task automatic acc(input logic [2:0] sel, input logic we, input logic [7:0] d);
        bus.mmap_sel = sel; bus.mem_en = 1'b1; bus.mem_we = we; bus.wr_data = d;
        @(negedge clk);
        bus.mem_en = 1'b0; bus.mem_we = 1'b0;
    endtask
    task automatic push(input logic [7:0] d);
        bus.uart_rx_valid = 1'b1; bus.uart_rx_data = d;
        @(negedge clk);
        bus.uart_rx_valid = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.mmap_sel = 3'd7; bus.mem_en = 0; bus.mem_we = 0; bus.wr_data = 0; bus.inst_retired = 0;
        bus.uart_rx_data = 0; bus.uart_rx_valid = 0; bus.uart_tx_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset rd_data", bus.rd_data, 32'h0);
        check("reset tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        check("reset rx_ready", 32'(bus.uart_rx_ready), 32'h1);
        // basic RX ordering
        push(8'h41); push(8'h42);
        acc(3'd1, 0, 0); check("rx first", bus.rd_data, 32'h41);
        acc(3'd1, 0, 0); check("rx second", bus.rd_data, 32'h42);
        acc(3'd0, 0, 0); check("ctrl after rx", bus.rd_data, 32'h1);
        // fill to full, hold a fifth byte
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        check("rx full ready", 32'(bus.uart_rx_ready), 32'h0);
        bus.uart_rx_valid = 1'b1; bus.uart_rx_data = 8'h14;
        idle(2);
        check("rx held ready", 32'(bus.uart_rx_ready), 32'h0);
        bus.uart_rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc(3'd1, 0, 0);
            check("rx drain", bus.rd_data, 32'(8'h10 + i));
        end
        push(8'h14);
        acc(3'd1, 0, 0); check("rx fifth", bus.rd_data, 32'h14);
        // TX hold and drop
        bus.uart_tx_ready = 1'b0;
        acc(3'd2, 1, 8'h55);
        check("tx busy", 32'(bus.uart_tx_valid), 32'h1);
        check("tx byte", 32'(bus.uart_tx_data), 32'h55);
        acc(3'd2, 1, 8'h66);
        idle(1);
        check("tx stable", 32'(bus.uart_tx_data), 32'h55);
        acc(3'd0, 0, 0); check("ctrl tx busy", bus.rd_data, FL ? 32'h4 : 32'h0);
        acc(3'd0, 0, 0); check("ctrl flags cleared", bus.rd_data, 32'h0);
        bus.uart_tx_ready = 1'b1;
        acc(3'd2, 1, 8'h77);
        bus.uart_tx_ready = 1'b0;
        check("tx released", 32'(bus.uart_tx_valid), 32'h0);
        check("tx not replaced", 32'(bus.uart_tx_data), 32'h55);
        acc(3'd0, 0, 0); check("ctrl drop on ready", bus.rd_data, FL ? 32'h5 : 32'h1);
        acc(3'd0, 0, 0); check("ctrl idle", bus.rd_data, 32'h1);
        acc(3'd2, 1, 8'h66);
        check("tx second byte", 32'(bus.uart_tx_data), 32'h66);
        bus.uart_tx_ready = 1'b1;
        idle(1);
        bus.uart_tx_ready = 1'b0;
        check("tx done", 32'(bus.uart_tx_valid), 32'h0);
        // counters
        acc(3'd5, 1, 0);
        for (int i = 0; i < 10; i++) begin
            bus.inst_retired = (i % 3 == 0);
            @(negedge clk);
        end
        bus.inst_retired = 1'b0;
        acc(3'd3, 0, 0); check("cycle count", bus.rd_data, 32'd10);
        acc(3'd4, 0, 0); check("inst count", bus.rd_data, 32'd4);
        bus.inst_retired = 1'b1;
        acc(3'd5, 1, 0);
        bus.inst_retired = 1'b0;
        acc(3'd4, 0, 0); check("clear beats inc", bus.rd_data, 32'd0);
        acc(3'd3, 0, 0); check("cycle after clear", bus.rd_data, 32'd1);
        // wrap and RX underflow
        acc(3'd5, 1, 0);
        idle(15);
        acc(3'd3, 0, 0); check("cycle max", bus.rd_data, 32'd15);
        acc(3'd3, 0, 0); check("cycle wrap", bus.rd_data, 32'd0);
        acc(3'd1, 0, 0); check("rx empty load", bus.rd_data, 32'h0);
        acc(3'd0, 0, 0); check("ctrl underflow", bus.rd_data, FL ? 32'h9 : 32'h1);
        bus.uart_rx_valid = 1'b1; bus.uart_rx_data = 8'h99;
        acc(3'd1, 0, 0);
        bus.uart_rx_valid = 1'b0;
        check("empty push+load", bus.rd_data, 32'h0);
        acc(3'd1, 0, 0); check("pushed byte", bus.rd_data, 32'h99);
        acc(3'd0, 0, 0); check("ctrl underflow again", bus.rd_data, FL ? 32'h9 : 32'h1);
        // asynchronous reset mid-operation
        acc(3'd2, 1, 8'h33); push(8'h01); push(8'h02);
        check("pre-reset busy", 32'(bus.uart_tx_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        check("async rd_data", bus.rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        acc(3'd0, 0, 0); check("ctrl after reset", bus.rd_data, 32'h1);
        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mmio_unit.md
Name: mmio_unit

Overview:
- Memory-mapped I/O back end; sits directly downstream of the pipeline controller in the memory/writeback stage.
- Consumes the decoded MMIO select and access strobes, owns the UART RX buffer and TX holding register, and owns the cycle and instruction counters.
- Returns registered load data to the writeback mux.

Parameters:
- RX_DEPTH, 4, RX FIFO entries; power of two, minimum 2.
- CNT_W, 32, cycle/instruction counter width; read data is zero-extended to 32 bits.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- mmap_sel  in  3  0=CTRL, 1=RX, 2=TX, 3=CYCLE_CNT, 4=INST_CNT, 5=CNT_RST, 6/7=none
- mem_en  in  1  valid MMIO access this cycle
- mem_we  in  1  1=store, 0=load
- wr_data  in  8  store byte (low byte of rs2)
- inst_retired  in  1  one-cycle pulse per retired instruction
- uart_rx_data  in  8  byte from UART receiver
- uart_rx_valid  in  1  receiver byte valid
- uart_rx_ready  out  1  combinational, = !rx_full
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  transmit byte valid
- uart_tx_ready  in  1  transmitter accepts
- rd_data  out  32  registered load result

Behaviour:
- Reset: RX FIFO empty, rx count 0; uart_tx_valid=0, uart_tx_data=0; both counters 0; rd_data=0; all flags 0.
- Access qualifier: load = mem_en && !mem_we; store = mem_en && mem_we. A load with sel 2 or 5, a store with sel 0/1/3/4, and any sel 6/7 are ignored. For an ignored load, rd_data=0 next cycle.
- Load latency: exactly 1 cycle; rd_data is updated on the clk edge after the access.
- A cycle with no load drives rd_data=0 on the next edge.
- CTRL read: {30'b0, rx_avail, tx_free}.
  - tx_free = !uart_tx_valid
  - rx_avail = rx count != 0
  - Both are sampled before this edge's updates.
- RX path:
  - Push when uart_rx_valid && uart_rx_ready.
  - A load with sel=1 while nonempty returns {24'b0, head} and pops.
  - A load with sel=1 while empty returns 0 and does not pop; count is unchanged.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
  - Full: uart_rx_ready=0 and no push.
  - Empty with push and RX load in the same cycle: the load sees empty (returns 0) and the push is accepted.
  - Pointers are log2(RX_DEPTH) bits and wrap modulo RX_DEPTH.
- TX path:
  - A store with sel=2 while uart_tx_valid=0 latches wr_data; uart_tx_valid=1 from the next cycle.
  - uart_tx_valid and uart_tx_data hold stable until the cycle where uart_tx_ready=1, after which uart_tx_valid=0.
  - A store while uart_tx_valid=1 is dropped, including the cycle uart_tx_ready=1; no queueing.
- Counters:
  - cycle_cnt increments every cycle.
  - inst_cnt increments when inst_retired=1.
  - Both wrap from 2^CNT_W-1 to 0.
  - A read (sel 3/4) returns the pre-increment value of that cycle.
  - A store with sel=5 sets both counters to 0 on that edge; clear wins over a simultaneous increment.
- States: TX holding register has two states, IDLE (valid=0) and BUSY (valid=1).
  - IDLE to BUSY on an accepted store.
  - BUSY to IDLE on uart_tx_ready.
- Reset mid-operation:
  - Asynchronous assertion immediately clears all state; a pending TX byte and buffered RX bytes are discarded.
  - uart_rx_ready=1 while rst is high is permitted, but no push occurs.

Optional Feature:
- Macro MMIO_ERR_FLAGS_EN.
- Defined:
  - CTRL bit2 = tx_drop, a sticky flag set by a dropped TX store.
  - CTRL bit3 = rx_underflow, a sticky flag set by an RX load while empty.
  - A CTRL load returns the current flags, then clears both on that edge.
  - A set event and a clear in the same cycle leave the flag set.
- Undefined: bits 2-3 read 0; no flag registers exist.

Test Plan:
- Reset, push 0x41,0x42 via uart_rx_valid, then two RX loads -> rd_data 0x41 then 0x42 one cycle after each; CTRL load then returns 0x1.
- Push RX_DEPTH+1 bytes without reads -> uart_rx_ready=0 after 4 pushes; 5th byte held by sender; 4 loads return bytes in order.
- Store 0x55 to TX with uart_tx_ready=0 for 3 cycles, second store 0x66 in between -> uart_tx_data=0x55 stable; 0x66 dropped; with macro, CTRL reads 0x4 (tx busy) and then clears.
- Run 10 cycles with 4 inst_retired pulses, load sel 3/4 -> cycle count value at sample edge, INST=4; store sel 5 coincident with a pulse -> next read INST=0.
- Preload cycle_cnt near wrap (CNT_W=4 build): 16 cycles -> reads 0 after 15; empty RX load -> rd_data 0; with macro, CTRL bit3=1.
- Assert rst asynchronously with TX BUSY and 2 RX bytes -> uart_tx_valid=0 before next edge; CTRL reads 0x1.
